// File: rtl/ecc_hamming_pkg.sv
// Shared helpers for the Hamming decoder pipeline: codeword position arithmetic and error classes.
package ecc_hamming_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        SEC   = 2'd1,
        DED   = 2'd2
    } err_class_e;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int unsigned syn_width(input int unsigned c);
        return $clog2(c + 1);
    endfunction

    // 1-based codeword position carrying data bit k: the k-th non-power-of-two position.
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned seen = 0;
        int unsigned pos  = 0;
        for (int unsigned j = 1; j < 256; j++) begin
            if (!is_pow2(j)) begin
                if (seen == k && pos == 0) pos = j;
                seen++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_hamming_syndrome.sv
// Combinational Hamming syndrome plus overall parity over a C-bit codeword (positions 1..C = bits 0..C-1).
module ecc_hamming_syndrome
    import ecc_hamming_pkg::*;
#(
    parameter int C  = 7,
    parameter int SW = syn_width(C)
) (
    input  logic [C-1:0]  cw_i,
    input  logic          extra_par_i,
    output logic [SW-1:0] syn_o,
    output logic          par_o
);

    always_comb begin
        syn_o = '0;
        for (int k = 0; k < SW; k++) begin
            for (int j = 1; j <= C; j++) begin
                if (((j >> k) & 1) != 0) begin
                    syn_o[k] = syn_o[k] ^ cw_i[j-1];
                end
            end
        end
        par_o = (^cw_i) ^ extra_par_i;
    end

endmodule

// File: rtl/ecc_hamming_decoder_pipe.sv
// Two-stage Hamming SEC/SECDED decoder, error counters only with ECC_HAMMING_ERR_CNT_EN defined.
// Latency 2 cycles; valid/ready backpressure stalls both stages and holds out_* while stalled.
module ecc_hamming_decoder_pipe
    import ecc_hamming_pkg::*;
#(
    parameter int D      = 4,
    parameter int DW     = D,
    parameter int C      = 7,
    parameter int SECDED = 1,
    localparam int P     = C - D,
    localparam int CW    = DW + P,
    localparam int EW    = syn_width(C)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_codeword,
    input  logic          in_extra_parity,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sec,
    output logic          out_ded,
    output logic [EW-1:0] out_err_pos,
    input  logic          cnt_clr,
    output logic [15:0]   sec_cnt,
    output logic [15:0]   ded_cnt
);

    localparam logic [EW-1:0] CW_POS = EW'(CW);

    if (P < 2 || DW > D) begin : g_bad_cfg
        $error("ecc_hamming_decoder_pipe: configuration needs C-D >= 2 and DW <= D");
    end

    logic          s1_valid_q;
    logic [C-1:0]  s1_cw_q;
    logic [EW-1:0] s1_syn_q;
    logic          s1_par_q;
    logic [C-1:0]  cw_ext;
    logic [EW-1:0] syn;
    logic          par;
    logic          advance;

    logic          out_valid_q;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_sec_q, out_sec_d;
    logic          out_ded_q, out_ded_d;
    logic [EW-1:0] out_pos_q, out_pos_d;
    err_class_e    cls;
    logic          flip;
    logic [C-1:0]  fixed_cw;

    // Shortened codes: positions above CW are absent and read as zero.
    always_comb begin
        cw_ext = '0;
        cw_ext[CW-1:0] = in_codeword;
    end

    ecc_hamming_syndrome #(
        .C  (C),
        .SW (EW)
    ) u_syndrome (
        .cw_i        (cw_ext),
        .extra_par_i (in_extra_parity),
        .syn_o       (syn),
        .par_o       (par)
    );

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_cw_q    <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_cw_q  <= cw_ext;
                s1_syn_q <= syn;
                s1_par_q <= par;
            end
        end
    end

    // A syndrome pointing past CW names a zero-filled position, so it can only be a multi-bit error.
    always_comb begin
        cls  = CLEAN;
        flip = 1'b0;
        if (SECDED != 0 && s1_par_q) begin
            if (s1_syn_q == '0) begin
                cls = SEC;
            end else if (s1_syn_q <= CW_POS) begin
                cls  = SEC;
                flip = 1'b1;
            end else begin
                cls = DED;
            end
        end else if (s1_syn_q != '0) begin
            if (SECDED == 0 && s1_syn_q <= CW_POS) begin
                cls  = SEC;
                flip = 1'b1;
            end else begin
                cls = DED;
            end
        end
    end

    always_comb begin
        fixed_cw = s1_cw_q;
        for (int j = 1; j <= C; j++) begin
            if (flip && s1_syn_q == EW'(j)) fixed_cw[j-1] = ~s1_cw_q[j-1];
        end
    end

    for (genvar k = 0; k < DW; k++) begin : g_data
        assign out_data_d[k] = fixed_cw[data_pos(k) - 1];
    end

    assign out_sec_d = (cls == SEC);
    assign out_ded_d = (cls == DED);
    assign out_pos_d = flip ? s1_syn_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sec_q   <= 1'b0;
            out_ded_q   <= 1'b0;
            out_pos_q   <= '0;
        end else if (advance) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_data_d;
                out_sec_q  <= out_sec_d;
                out_ded_q  <= out_ded_d;
                out_pos_q  <= out_pos_d;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sec     = out_sec_q;
    assign out_ded     = out_ded_q;
    assign out_err_pos = out_pos_q;

`ifdef ECC_HAMMING_ERR_CNT_EN
    logic [15:0] sec_cnt_q, ded_cnt_q;
    logic        out_fire;

    assign out_fire = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else if (out_fire) begin
            if (out_sec_q && sec_cnt_q != 16'hFFFF) sec_cnt_q <= sec_cnt_q + 16'd1;
            if (out_ded_q && ded_cnt_q != 16'hFFFF) ded_cnt_q <= ded_cnt_q + 16'd1;
        end
    end

    assign sec_cnt = sec_cnt_q;
    assign ded_cnt = ded_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sec_cnt        = '0;
    assign ded_cnt        = '0;
`endif

endmodule

// File: tb/tb_ecc_hamming_decoder_pipe.sv
// Scoreboard bench for the (7,4) SECDED decoder pipeline with a position-XOR reference model.
module tb_ecc_hamming_decoder_pipe;

    typedef struct {
        logic [3:0] data;
        logic       sec;
        logic       ded;
        logic [2:0] pos;
        int         cyc;
        bit         nobp;
    } exp_t;

    localparam int CWB = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_codeword = '0;
    logic        in_extra_parity = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_data;
    logic        out_sec;
    logic        out_ded;
    logic [2:0]  out_err_pos;
    logic        cnt_clr = 1'b0;
    logic [15:0] sec_cnt;
    logic [15:0] ded_cnt;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    ecc_hamming_decoder_pipe dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_codeword     (in_codeword),
        .in_extra_parity (in_extra_parity),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_sec         (out_sec),
        .out_ded         (out_ded),
        .out_err_pos     (out_err_pos),
        .cnt_clr         (cnt_clr),
        .sec_cnt         (sec_cnt),
        .ded_cnt         (ded_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Syndrome as the XOR of the indices of all set positions; data sits at positions 3,5,6,7.
    function automatic exp_t ref_model(input logic [6:0] cw, input logic ep);
        exp_t       e;
        int         syn = 0;
        int         ones = 0;
        logic       par;
        logic [6:0] fx = cw;
        int         dpos[4] = '{3, 5, 6, 7};
        for (int j = 1; j <= 7; j++) begin
            if (cw[j-1]) begin
                syn ^= j;
                ones++;
            end
        end
        par = ((ones % 2) != 0) ^ ep;
        e.sec = 1'b0; e.ded = 1'b0; e.pos = '0; e.cyc = 0; e.nobp = 1'b0;
        if (!par && syn == 0) begin
        end else if (par && syn == 0) begin
            e.sec = 1'b1;
        end else if (par && syn <= CWB) begin
            fx[syn-1] = ~fx[syn-1];
            e.sec = 1'b1;
            e.pos = 3'(syn);
        end else begin
            e.ded = 1'b1;
        end
        for (int k = 0; k < 4; k++) e.data[k] = fx[dpos[k]-1];
        return e;
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] cw = '0;
        int         syn = 0;
        int         dpos[4] = '{3, 5, 6, 7};
        for (int k = 0; k < 4; k++) cw[dpos[k]-1] = d[k];
        for (int j = 1; j <= 7; j++) if (cw[j-1]) syn ^= j;
        for (int b = 0; b < 3; b++) if (syn[b]) cw[(1 << b) - 1] = 1'b1;
        return cw;
    endfunction

    function automatic exp_t mk(input logic [3:0] d, input logic s, input logic dd, input logic [2:0] p);
        exp_t e;
        e.data = d; e.sec = s; e.ded = dd; e.pos = p; e.cyc = 0; e.nobp = 1'b0;
        return e;
    endfunction

    task automatic send(input logic [6:0] cw, input logic ep, input exp_t e);
        int guard = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_codeword = cw;
        in_extra_parity = ep;
        while (!acc && guard < 1000) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                e.cyc  = cyc;
                e.nobp = (rdy_mode == 0);
                exp_q.push_back(e);
            end
            step();
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) fail_now("send_timeout");
    endtask

    task automatic send_rand();
        logic [6:0] cw;
        logic       ep;
        int         a;
        int         b;
        cw = encode(4'($urandom));
        ep = ^cw;
        case ($urandom % 5)
            1: begin a = $urandom_range(0, 6); cw[a] = ~cw[a]; end
            2: begin
                a = $urandom_range(0, 6);
                b = (a + 1 + $urandom_range(0, 5)) % 7;
                cw[a] = ~cw[a];
                cw[b] = ~cw[b];
            end
            3: ep = ~ep;
            4: begin cw = 7'($urandom); ep = 1'($urandom); end
            default: ;
        endcase
        send(cw, ep, ref_model(cw, ep));
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            step();
            g++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        repeat (2) step();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    // Monitor: pops and compares on every output handshake, checks hold-while-stalled and counters.
    initial begin
        exp_t        e;
        bit          got;
        bit          prev_stall = 1'b0;
        bit          prev_rst = 1'b0;
        logic [3:0]  p_data = '0;
        logic        p_sec = 1'b0;
        logic        p_ded = 1'b0;
        logic [2:0]  p_pos = '0;
        logic [15:0] m_sec = '0;
        logic [15:0] m_ded = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            got = 1'b0;
            chk("sec_cnt", 32'(sec_cnt), 32'(m_sec));
            chk("ded_cnt", 32'(ded_cnt), 32'(m_ded));
            if (prev_rst && !rst) begin
                chk("in_ready_after_rst", 32'(in_ready), 32'd1);
                chk("out_valid_after_rst", 32'(out_valid), 32'd0);
            end
            if (rst) begin
                exp_q.delete();
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'(out_data), 32'(p_data));
                    chk("stall_flags", 32'({out_sec, out_ded, out_err_pos}), 32'({p_sec, p_ded, p_pos}));
                end
                if (out_valid) chk("sec_ded_excl", 32'(out_sec & out_ded), 32'd0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        e = exp_q.pop_front();
                        got = 1'b1;
                        chk("out_data", 32'(out_data), 32'(e.data));
                        chk("out_sec", 32'(out_sec), 32'(e.sec));
                        chk("out_ded", 32'(out_ded), 32'(e.ded));
                        chk("out_err_pos", 32'(out_err_pos), 32'(e.pos));
                        if (e.nobp) chk("latency", 32'(cyc - e.cyc), 32'd2);
                    end
                end
            end
`ifdef ECC_HAMMING_ERR_CNT_EN
            if (rst || cnt_clr) begin
                m_sec = '0;
                m_ded = '0;
            end else if (got) begin
                if (e.sec && m_sec != 16'hFFFF) m_sec = m_sec + 16'd1;
                if (e.ded && m_ded != 16'hFFFF) m_ded = m_ded + 16'd1;
            end
`endif
            prev_stall = !rst && out_valid && !out_ready;
            prev_rst   = rst;
            p_data = out_data; p_sec = out_sec; p_ded = out_ded; p_pos = out_err_pos;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_flags", 32'({out_sec, out_ded, out_err_pos}), 32'd0);
        chk("rst_sec_cnt", 32'(sec_cnt), 32'd0);
        chk("rst_ded_cnt", 32'(ded_cnt), 32'd0);
        rst = 1'b0;
        step();
        chk("in_ready_post_rst", 32'(in_ready), 32'd1);
        mon_en = 1'b1;

        rdy_mode = 0;
        send(7'h55, 1'b0, mk(4'hB, 1'b0, 1'b0, 3'd0));
        send(7'h45, 1'b0, mk(4'hB, 1'b1, 1'b0, 3'd5));
        send(7'h56, 1'b0, mk(4'hB, 1'b0, 1'b1, 3'd0));
        send(7'h55, 1'b1, mk(4'hB, 1'b1, 1'b0, 3'd0));
        drain();
`ifdef ECC_HAMMING_ERR_CNT_EN
        chk("dir_sec_cnt", 32'(sec_cnt), 32'd2);
        chk("dir_ded_cnt", 32'(ded_cnt), 32'd1);
`endif

        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send_rand();
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom % 3 == 0) step();
            send_rand();
        end
        drain();

        for (int i = 0; i < 6; i++) send_rand();
        rst = 1'b1;
        cnt_clr = 1'b1;
        step();
        rst = 1'b0;
        cnt_clr = 1'b0;
        repeat (3) step();

        rdy_mode = 0;
        fork
            for (int i = 0; i < 10; i++) send_rand();
            begin
                repeat (5) step();
                cnt_clr = 1'b1;
                step();
                cnt_clr = 1'b0;
            end
        join
        drain();

`ifdef ECC_HAMMING_ERR_CNT_EN
        for (int i = 0; i < 65540; i++) send(7'h56, 1'b0, ref_model(7'h56, 1'b0));
        drain();
        chk("ded_cnt_saturated", 32'(ded_cnt), 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ecc_hamming_decoder_pipe.md
ECC_HAMMING_DECODER_PIPE -- requirements
Module: ecc_hamming_decoder_pipe

Interface
REQ-001 SHALL have parameter D, default 4: maximum data bits of the Hamming code.
REQ-002 SHALL have parameter DW, default D: data bits actually used; DW <= D.
REQ-003 SHALL have parameter C, default 7: full codeword bits.
REQ-004 SHALL have parameter SECDED, default 1: 1 = extra parity checked, 0 = SEC only.
REQ-005 SHALL have derived parameters P = C-D and CW = DW+P, not to be overridden.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1 bit: codeword present.
REQ-009 SHALL have port in_ready, output, 1 bit: stage 1 can accept.
REQ-010 SHALL have port in_codeword, input, CW bits: codeword in encoder bit layout.
REQ-011 SHALL have port in_extra_parity, input, 1 bit: XOR of codeword; ignored when SECDED=0.
REQ-012 SHALL have port out_valid, output, 1 bit: result present.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts.
REQ-014 SHALL have port out_data, output, DW bits: corrected data.
REQ-015 SHALL have port out_sec, output, 1 bit: single error corrected.
REQ-016 SHALL have port out_ded, output, 1 bit: uncorrectable error.
REQ-017 SHALL have port out_err_pos, output, $clog2(C+1) bits: 1-based flipped position, 0 = none or extra parity.
REQ-018 SHALL have port cnt_clr, input, 1 bit: clear error counters.
REQ-019 SHALL have port sec_cnt, output, 16 bits: corrected-error count.
REQ-020 SHALL have port ded_cnt, output, 16 bits: uncorrectable-error count.

Function
REQ-021 SHALL zero-extend in_codeword to C bits at positions above CW before syndrome computation.
REQ-022 SHALL compute in stage 1 syndrome bit k as XOR of all positions j (1..C) with j[k]=1, plus overall parity ^codeword ^ in_extra_parity, and register syndrome, codeword and overall parity.
REQ-023 SHALL classify in stage 2, for SECDED=1: syndrome 0 and parity 0 -> clean; parity 1 and syndrome 0 -> out_sec, err_pos 0 (extra parity bit only); parity 1 and 1 <= syndrome <= CW -> flip position syndrome, out_sec; syndrome != 0 and parity 0 -> out_ded, data uncorrected.
REQ-024 SHALL classify for SECDED=0: syndrome 0 -> clean; 1..CW -> correct, out_sec; otherwise -> out_ded.
REQ-025 SHALL treat syndrome > CW (zero-filled position) as out_ded, data uncorrected, err_pos 0.
REQ-026 SHALL extract out_data from non-power-of-two positions in ascending order, first DW only; out_sec and out_ded never both 1.
REQ-027 SHALL have latency of exactly 2 cycles from the in_valid&in_ready edge to out_valid with no backpressure.
REQ-028 SHALL define advance = !out_valid | out_ready; in_ready = !s1_valid | advance; throughput of 1 word/cycle under continuous out_ready.
REQ-029 SHALL hold out_* stable while out_valid & !out_ready; no word dropped or duplicated.
REQ-030 SHALL update counters only on the out_valid&out_ready edge, saturating at 16'hFFFF.
REQ-031 SHALL give cnt_clr priority over a same-cycle increment, with counters reading 0 the next cycle.

Reset
REQ-032 SHALL clear s1_valid, out_valid, out_sec, out_ded, out_err_pos, out_data, sec_cnt and ded_cnt to 0 on rst; in_ready SHALL be 1 the cycle after rst deasserts.
REQ-033 SHALL discard in-flight words on rst asserted mid-stream, with no counter update for them.

Configuration
REQ-034 SHALL, with ECC_HAMMING_ERR_CNT_EN defined, implement counters per REQ-030/031.
REQ-035 SHALL, without ECC_HAMMING_ERR_CNT_EN, keep the sec_cnt/ded_cnt ports, tie them to 0, ignore cnt_clr and instantiate no counter flops.

Structure
REQ-036 SHALL provide package ecc_hamming_pkg holding the function popcount-free position helpers (is_pow2, syndrome width) and an error-class enum {CLEAN, SEC, DED}.
REQ-037 SHALL use one sub-module, ecc_hamming_syndrome (combinational syndrome + overall parity), which is reusable by other ECC stages.
REQ-038 SHALL reject P < 2 or DW > D with elaboration error.

Verification
REQ-039 SHALL verify (7,4) default with 7'h55, ep 0 -> out_data 4'hB, sec 0, ded 0, 2 cycles later.
REQ-040 SHALL verify 7'h45 (position 5 flipped), ep 0 -> out_data 4'hB, out_sec 1, err_pos 5, sec_cnt 1.
REQ-041 SHALL verify 7'h56 (positions 1,2 flipped), ep 0 -> out_ded 1, err_pos 0, ded_cnt 1.
REQ-042 SHALL verify 7'h55, ep 1 -> out_data 4'hB, out_sec 1, err_pos 0.
REQ-043 SHALL verify 8 back-to-back words with out_ready toggling 1010 -> all 8 delivered in order, outputs stable while stalled.
REQ-044 SHALL verify cnt_clr with rst mid-stream -> counters 0, no output the cycle after rst, and counters saturate at 16'hFFFF after forced 65536+ errors.
